// File: rtl/commit_ctrl_pkg.sv
// commit_ctrl_pkg: shared state enum, instruction-type codes and ROB entry layout for the commit controller
package commit_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, ST_WAIT, FLUSH} commit_state_t;
  localparam logic [1:0] ITYPE_BRANCH = 2'b00;
  localparam logic [1:0] ITYPE_STORE = 2'b01;
  typedef struct packed {
    logic [1:0] itype;
    logic branch_result;
    logic [3:0] ROB_number;
    logic [4:0] dest;
    logic [31:0] value;
  } ROB_entry_t;
endpackage

// File: rtl/commit_ctrl_if.sv
// commit_ctrl_if: ROB head (head/head_ready/rob_empty/rd_en) and store-queue (st_commit/st_done) handshakes; master = commit controller
interface commit_ctrl_if;
  import commit_ctrl_pkg::*;
  ROB_entry_t head;
  logic head_ready;
  logic rob_empty;
  logic rd_en;
  logic st_commit;
  logic st_done;
  modport master(input head, head_ready, rob_empty, st_done, output rd_en, st_commit);
  modport slave(output head, head_ready, rob_empty, st_done, input rd_en, st_commit);
endinterface

// File: rtl/commit_timer.sv
// commit_timer: loadable up/down counter (clk, reset, load/val, en, up -> cnt) shared by flush duration and store timeout
module commit_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic         up,
  input  logic [W-1:0] val,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk)
    if (reset) cnt <= '0;
    else if (load) cnt <= val;
    else if (en) cnt <= up ? cnt + W'(1) : cnt - W'(1);
endmodule

// File: rtl/commit_ctrl.sv
// commit_ctrl: in-order retirement (clk, reset, bus = ROB/store-queue handshakes; rf_* write port, rat_clr_rob, flush/redirect_pc, retired_cnt, st_timeout_err)
module commit_ctrl
  import commit_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int ST_TIMEOUT = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  commit_ctrl_if.master    bus,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic [3:0]       rat_clr_rob,
  output logic             flush,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             st_timeout_err
);
  localparam int TW = $clog2((ST_TIMEOUT > FLUSH_CYCLES ? ST_TIMEOUT : FLUSH_CYCLES) + 1);
  commit_state_t state;
  logic idle_go, is_st, mispredict, st_fire, tmr_en;
  logic [TW-1:0] tmr_cnt, tmr_val;
  always_comb begin
    idle_go = !reset && state == IDLE && !bus.rob_empty && bus.head_ready;
    is_st = bus.head.itype == ITYPE_STORE;
    mispredict = idle_go && bus.head.itype == ITYPE_BRANCH && bus.head.branch_result;
    st_fire = !reset && state == ST_WAIT && bus.st_done && !bus.rob_empty && bus.head_ready;
    bus.rd_en = (idle_go && !is_st) || st_fire;
    rf_we = idle_go && bus.head.itype[1];
    rf_waddr = rf_we ? bus.head.dest : '0;
    rf_wdata = rf_we ? bus.head.value : '0;
    rat_clr_rob = rf_we ? bus.head.ROB_number : '0;
    tmr_val = mispredict ? TW'(FLUSH_CYCLES - 1) : '0;
    tmr_en = state == FLUSH || (state == ST_WAIT && tmr_cnt != TW'(ST_TIMEOUT));
  end
  // idle cycles keep reloading so each store wait or flush starts from a fresh value
  commit_timer #(.W(TW)) u_timer (
    .clk(clk), .reset(reset), .load(state == IDLE), .en(tmr_en),
    .up(state == ST_WAIT), .val(tmr_val), .cnt(tmr_cnt)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      bus.st_commit <= 1'b0;
      flush <= 1'b0;
      redirect_pc <= '0;
      retired_cnt <= '0;
      st_timeout_err <= 1'b0;
    end else begin
      retired_cnt <= retired_cnt + CNT_W'(bus.rd_en);
      if (state == IDLE) begin
        if (mispredict) begin
          state <= FLUSH;
          flush <= 1'b1;
          redirect_pc <= bus.head.value;
        end else if (idle_go && is_st) begin
          state <= ST_WAIT;
          bus.st_commit <= 1'b1;
        end
      end else if (state == ST_WAIT) begin
        if (!st_fire && tmr_cnt == TW'(ST_TIMEOUT - 1)) st_timeout_err <= 1'b1;
        if (st_fire) begin
          state <= IDLE;
          bus.st_commit <= 1'b0;
        end
      end else if (tmr_cnt == '0) begin
        state <= IDLE;
        flush <= 1'b0;
        redirect_pc <= '0;
      end
    end
endmodule

// File: tb/tb_commit_ctrl.sv
// tb_commit_ctrl: directed self-checking bench for commit_ctrl
module tb_commit_ctrl;
  import commit_ctrl_pkg::*;
  logic clk = 0, reset = 1;
  logic rf_we, flush, st_timeout_err;
  logic [4:0] rf_waddr;
  logic [31:0] rf_wdata, redirect_pc, retired_cnt;
  logic [3:0] rat_clr_rob;
  int checks = 0, errors = 0;
  commit_ctrl_if bus();
  commit_ctrl dut (
    .clk(clk), .reset(reset), .bus(bus), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .rat_clr_rob(rat_clr_rob), .flush(flush),
    .redirect_pc(redirect_pc), .retired_cnt(retired_cnt), .st_timeout_err(st_timeout_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic ROB_entry_t ent(logic [1:0] t, logic br, logic [3:0] rn, logic [4:0] d, logic [31:0] v);
    ROB_entry_t e;
    e.itype = t;
    e.branch_result = br;
    e.ROB_number = rn;
    e.dest = d;
    e.value = v;
    return e;
  endfunction
  task automatic idle_rob;
    bus.rob_empty = 1;
    bus.head_ready = 0;
    bus.st_done = 0;
  endtask
  initial begin
    bus.head = '0;
    idle_rob();
    tick();
    tick();
    chk("rst_rd_en", bus.rd_en, 0);
    chk("rst_st_commit", bus.st_commit, 0);
    chk("rst_flush", flush, 0);
    chk("rst_redirect", redirect_pc, 0);
    chk("rst_cnt", retired_cnt, 0);
    chk("rst_err", st_timeout_err, 0);
    reset = 0;
    tick();
    bus.rob_empty = 0;
    bus.head_ready = 1;
    for (int i = 0; i < 3; i++) begin
      bus.head = ent(2'b10, 0, 4'(i + 1), 5'(5 + i), 32'hA + 32'(i));
      #1;
      chk("b2b_rd_en", bus.rd_en, 1);
      chk("b2b_rf_we", rf_we, 1);
      chk("b2b_waddr", rf_waddr, 5 + i);
      chk("b2b_wdata", rf_wdata, 32'hA + i);
      chk("b2b_rat", rat_clr_rob, i + 1);
      tick();
    end
    idle_rob();
    #1;
    chk("idle_rf_we", rf_we, 0);
    chk("idle_waddr", rf_waddr, 0);
    chk("b2b_cnt", retired_cnt, 3);
    bus.head = ent(2'b11, 0, 4, 8, 32'h55);
    bus.head_ready = 1;
    #1;
    chk("empty_ready_rd_en", bus.rd_en, 0);
    tick();
    bus.rob_empty = 0;
    bus.head_ready = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stall_rd_en", bus.rd_en, 0);
      tick();
    end
    bus.head_ready = 1;
    #1;
    chk("stall_go_rd_en", bus.rd_en, 1);
    chk("stall_go_rat", rat_clr_rob, 4);
    tick();
    idle_rob();
    #1;
    chk("stall_cnt", retired_cnt, 4);
    bus.st_done = 1;
    #1;
    chk("stray_done_rd_en", bus.rd_en, 0);
    tick();
    bus.st_done = 0;
    bus.head = ent(ITYPE_STORE, 0, 5, 0, 0);
    bus.rob_empty = 0;
    bus.head_ready = 1;
    #1;
    chk("st_issue_rd_en", bus.rd_en, 0);
    chk("st_issue_commit", bus.st_commit, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("st_wait_commit", bus.st_commit, 1);
      chk("st_wait_rd_en", bus.rd_en, 0);
      tick();
    end
    bus.st_done = 1;
    #1;
    chk("st_done_commit", bus.st_commit, 1);
    chk("st_done_rd_en", bus.rd_en, 1);
    chk("st_done_rf_we", rf_we, 0);
    tick();
    idle_rob();
    #1;
    chk("st_commit_drop", bus.st_commit, 0);
    chk("st_cnt", retired_cnt, 5);
    bus.head = ent(ITYPE_BRANCH, 0, 6, 3, 32'h40);
    bus.rob_empty = 0;
    bus.head_ready = 1;
    #1;
    chk("br_ok_rd_en", bus.rd_en, 1);
    chk("br_ok_rf_we", rf_we, 0);
    tick();
    bus.head = ent(ITYPE_BRANCH, 1, 7, 0, 32'h1000);
    #1;
    chk("mp_rd_en", bus.rd_en, 1);
    chk("mp_flush_early", flush, 0);
    tick();
    bus.head = ent(2'b10, 0, 8, 9, 32'h77);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("fl_flush", flush, 1);
      chk("fl_redirect", redirect_pc, 32'h1000);
      chk("fl_rd_en", bus.rd_en, 0);
      chk("fl_rf_we", rf_we, 0);
      tick();
    end
    idle_rob();
    #1;
    chk("fl_done", flush, 0);
    chk("fl_cnt", retired_cnt, 7);
    bus.head = ent(ITYPE_STORE, 0, 9, 0, 0);
    bus.rob_empty = 0;
    bus.head_ready = 1;
    tick();
    repeat (63) tick();
    chk("to_err_early", st_timeout_err, 0);
    tick();
    chk("to_err_set", st_timeout_err, 1);
    repeat (5) tick();
    chk("to_err_sticky", st_timeout_err, 1);
    bus.st_done = 1;
    #1;
    chk("to_done_rd_en", bus.rd_en, 1);
    tick();
    idle_rob();
    #1;
    chk("to_commit_drop", bus.st_commit, 0);
    chk("to_err_hold", st_timeout_err, 1);
    chk("to_cnt", retired_cnt, 8);
    reset = 1;
    tick();
    reset = 0;
    chk("rst_err_clr", st_timeout_err, 0);
    chk("rst_cnt_clr", retired_cnt, 0);
    bus.head = ent(ITYPE_STORE, 0, 10, 0, 0);
    bus.rob_empty = 0;
    bus.head_ready = 1;
    tick();
    tick();
    chk("rw_commit", bus.st_commit, 1);
    reset = 1;
    idle_rob();
    tick();
    reset = 0;
    chk("rw_commit_clr", bus.st_commit, 0);
    chk("rw_cnt", retired_cnt, 0);
    bus.head = ent(2'b10, 0, 11, 12, 32'h99);
    bus.rob_empty = 0;
    bus.head_ready = 1;
    #1;
    chk("rw_idle_rf_we", rf_we, 1);
    tick();
    chk("rw_cnt_inc", retired_cnt, 1);
    bus.head = ent(ITYPE_BRANCH, 1, 12, 0, 32'h2000);
    tick();
    chk("rf_flush", flush, 1);
    chk("rf_redirect", redirect_pc, 32'h2000);
    reset = 1;
    idle_rob();
    tick();
    reset = 0;
    chk("rf_flush_clr", flush, 0);
    chk("rf_redirect_clr", redirect_pc, 0);
    chk("rf_cnt_clr", retired_cnt, 0);
    bus.head = ent(2'b10, 0, 13, 14, 32'h123);
    bus.rob_empty = 0;
    bus.head_ready = 1;
    #1;
    chk("rf_idle_rf_we", rf_we, 1);
    chk("rf_idle_rat", rat_clr_rob, 13);
    tick();
    idle_rob();
    #1;
    chk("rf_idle_flush", flush, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
